// File: rtl/mips_trace_pkg.sv
// ============================================================================
// Module : mips_trace_pkg
// Brief  : Opcode/funct constants, retire class codes and the class decoder
//          shared by the MIPS retire-trace monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_trace_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_MADDU = 6'd28;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_NOP   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [4:0] CLS_UNKNOWN = 5'd0;
  localparam logic [4:0] CLS_ADD     = 5'd1;
  localparam logic [4:0] CLS_SUB     = 5'd2;
  localparam logic [4:0] CLS_AND     = 5'd3;
  localparam logic [4:0] CLS_OR      = 5'd4;
  localparam logic [4:0] CLS_SRL     = 5'd5;
  localparam logic [4:0] CLS_NOP     = 5'd6;
  localparam logic [4:0] CLS_SLT     = 5'd7;
  localparam logic [4:0] CLS_MULTU   = 5'd8;
  localparam logic [4:0] CLS_MFHI    = 5'd9;
  localparam logic [4:0] CLS_MFLO    = 5'd10;
  localparam logic [4:0] CLS_ADDIU   = 5'd11;
  localparam logic [4:0] CLS_MADDU   = 5'd12;
  localparam logic [4:0] CLS_LW      = 5'd13;
  localparam logic [4:0] CLS_SW      = 5'd14;
  localparam logic [4:0] CLS_BEQ     = 5'd15;
  localparam logic [4:0] CLS_J       = 5'd16;

  localparam int NUM_CLASSES = 17;

  function automatic logic [4:0] decode_class(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] cls;
    op  = instr[31:26];
    fn  = instr[5:0];
    cls = CLS_UNKNOWN;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_ADD:   cls = CLS_ADD;
        FN_SUB:   cls = CLS_SUB;
        FN_AND:   cls = CLS_AND;
        FN_OR:    cls = CLS_OR;
        FN_SRL:   cls = CLS_SRL;
        FN_NOP:   cls = CLS_NOP;
        FN_SLT:   cls = CLS_SLT;
        FN_MULTU: cls = CLS_MULTU;
        FN_MFHI:  cls = CLS_MFHI;
        FN_MFLO:  cls = CLS_MFLO;
        default:  cls = CLS_UNKNOWN;
      endcase
    end else begin
      case (op)
        OP_ADDIU: cls = CLS_ADDIU;
        OP_MADDU: cls = CLS_MADDU;
        OP_LW:    cls = CLS_LW;
        OP_SW:    cls = CLS_SW;
        OP_BEQ:   cls = CLS_BEQ;
        OP_J:     cls = CLS_J;
        default:  cls = CLS_UNKNOWN;
      endcase
    end
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_trace_fifo.sv
// ============================================================================
// Module : mips_trace_fifo
// Brief  : Synchronous first-word-fall-through FIFO; head reads as zero when
//          empty so downstream fields are quiet without a valid record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_ZERO  = '0;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == c_DEPTH);
  assign o_empty   = (r_count == c_ZERO);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_retire_tracer.sv
// ============================================================================
// Module : mips_retire_tracer
// Brief  : Retire-trace monitor: classifies retired instructions, counts them
//          per class, stamps them with a cycle counter and queues trace records.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_retire_tracer
  import mips_trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr,
  input  logic              retire_valid,
  input  logic [ADDR_W-1:0] retire_pc,
  input  logic [31:0]       retire_instr,
  input  logic [DATA_W-1:0] retire_wd,
  output logic              trace_valid,
  input  logic              trace_rdy,
  output logic [CNT_W-1:0]  trace_cycle,
  output logic [ADDR_W-1:0] trace_pc,
  output logic [4:0]        trace_class,
  output logic [DATA_W-1:0] trace_wd,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count,
  input  logic [4:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_value,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int REC_W = CNT_W + ADDR_W + 5 + DATA_W;
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_cnt      [NUM_CLASSES];
  logic [CNT_W-1:0] w_cnt_next [NUM_CLASSES];
  logic [CNT_W-1:0] r_cnt_value;
  logic [CNT_W-1:0] r_drop;
  logic             r_overflow;
  logic [4:0]       w_class;
  logic             w_capture;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic             w_push;
  logic [REC_W-1:0] w_head;

  assign w_class   = decode_class(retire_instr);
  assign w_capture = retire_valid & enable & ~clr & ~rst;
  assign w_pop     = trace_valid & trace_rdy;
  assign w_drop    = w_capture & w_full & ~w_pop;
  assign w_push    = w_capture & ~w_drop;

  mips_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_data  ({r_cycle, retire_pc, w_class, retire_wd}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign trace_valid = ~w_empty;
  assign {trace_cycle, trace_pc, trace_class, trace_wd} = w_head;

  // Free-running; clr deliberately leaves it alone so stamps stay monotonic.
  always_ff @(posedge clk) begin
    if (rst) r_cycle <= '0;
    else     r_cycle <= r_cycle + c_ONE;
  end

  // Class counters count every captured retire, dropped or not.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_capture && (r_cnt[w_class] != '1)) begin
      w_cnt_next[w_class] = r_cnt[w_class] + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
      r_cnt_value <= '0;
      r_drop      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      // Read the post-edge value so a retire shows up in the very next cycle.
      r_cnt_value <= (cnt_sel < 5'(NUM_CLASSES)) ? w_cnt_next[cnt_sel] : '0;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + c_ONE;
      end
    end
  end

  assign cycle_count = r_cycle;
  assign cnt_value   = r_cnt_value;
  assign drop_count  = r_drop;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire
